fetch_pc_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer. It holds the architectural PC and presents it to the branch control unit, which computes PC_next. It latches PC_next when execute signals completion. It fetches each instruction over a req/ack handshake with instruction memory and hands it to decode over a valid/ready handshake. The core is multi-cycle: one instruction is in flight at a time.

---
 rtl/fetch_pc_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Holds the architectural program counter and sequences one instruction at a
// time through fetch -> issue -> execute. The PC is presented to the branch
// control unit continuously. The PC only moves when execute commits an aligned
// PC_next, so the BCU input stays stable while a fetch and an issue are in
// progress. A misaligned commit parks the unit in a terminal fault state until
// the next reset.
//
// Ports
//   clk            system clock, rising-edge active
//   n_reset        asynchronous active-low reset
//   PC             current PC, to the BCU
//   PC_next        next PC from the BCU
//   pc_update      execute done; commit PC_next
//   imem_req       instruction memory request
//   imem_addr      fetch address (always the current PC)
//   imem_ack       memory response valid
//   imem_rdata     fetched instruction word
//   instr          instruction register, to decode
//   instr_PC       PC of the word held in instr
//   instr_valid    instr valid, to decode
//   instr_ready    decode accepts instr
//   misalign_fault sticky flag, set by a misaligned commit
//   instret        retired instruction count, wraps modulo 2^COUNT_W
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,  // must be word aligned
    parameter int          COUNT_W      = 32
) (
    input  logic               clk,
    input  logic               n_reset,
    output logic [31:0]        PC,
    input  logic [31:0]        PC_next,
    input  logic               pc_update,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instr,
    output logic [31:0]        instr_PC,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               misalign_fault,
    output logic [COUNT_W-1:0] instret
);

    typedef enum logic [1:0] {
        S_FETCH     = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_EXEC = 2'd2,
        S_FAULT     = 2'd3
    } state_t;

    // Fetched word and the PC it was fetched from travel together.
    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } ibuf_t;

    state_t              state;
    ibuf_t               ibuf;
    logic [31:0]         pc_q;
    logic [COUNT_W-1:0]  ret_q;
    logic                req_q;
    logic                valid_q;
    logic                fault_q;

    logic                target_aligned;

    assign target_aligned = (PC_next[1:0] == 2'b00);

    // Handshake outputs are registered and written alongside the state
    // transition, so each one already reflects the state being entered.
    // imem_req resets low and rises on the first edge after reset release;
    // the state is FETCH throughout, so an ack in that first cycle is still
    // accepted.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= S_FETCH;
            pc_q    <= RESET_VECTOR;
            ibuf    <= '0;
            ret_q   <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    // pc_update is meaningless here; only the ack can act.
                    req_q   <= 1'b1;
                    valid_q <= 1'b0;
                    if (imem_ack) begin
                        ibuf.word <= imem_rdata;
                        ibuf.pc   <= pc_q;
                        req_q     <= 1'b0;
                        valid_q   <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b1;
                    if (instr_ready) begin
                        valid_q <= 1'b0;
                        state   <= S_WAIT_EXEC;
                    end
                end

                S_WAIT_EXEC: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    if (pc_update) begin
                        if (target_aligned) begin
                            pc_q  <= PC_next;
                            ret_q <= ret_q + 1'b1;
                            req_q <= 1'b1;
                            state <= S_FETCH;
                        end else begin
                            // PC and count stay put so the faulting commit
                            // can be inspected from the last good PC.
                            fault_q <= 1'b1;
                            state   <= S_FAULT;
                        end
                    end
                end

                S_FAULT: begin
                    // Terminal: only reset leaves this state.
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    fault_q <= 1'b1;
                end

                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state   <= S_FAULT;
                end
            endcase
        end
    end

    assign PC             = pc_q;
    assign imem_addr      = pc_q;   // driven in every state, never X
    assign imem_req       = req_q;
    assign instr          = ibuf.word;
    assign instr_PC       = ibuf.pc;
    assign instr_valid    = valid_q;
    assign misalign_fault = fault_q;
    assign instret        = ret_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Drives fetch_pc_unit as memory, decode and execute would. The expected
// {word, pc} for each fetch is pushed when the ack is driven and popped when
// instr_valid appears. A small model tracks PC and the retired count. The
// counter is narrowed to 4 bits so wrap can be reached quickly.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          n_reset;
    logic [31:0]   PC;
    logic [31:0]   PC_next;
    logic          pc_update;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic [31:0]   instr;
    logic [31:0]   instr_PC;
    logic          instr_valid;
    logic          instr_ready;
    logic          misalign_fault;
    logic [CW-1:0] instret;

    fetch_pc_unit #(.RESET_VECTOR(32'h0000_0000), .COUNT_W(CW)) dut (
        .clk(clk), .n_reset(n_reset), .PC(PC), .PC_next(PC_next),
        .pc_update(pc_update), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .instr_PC(instr_PC), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .misalign_fault(misalign_fault),
        .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   m_pc;
    logic [CW-1:0] m_ret;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Reset, release on a falling edge, then let one rising edge pass so the
    // unit is presenting its first request when this task returns.
    task automatic apply_reset();
        n_reset = 1'b0; pc_update = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        PC_next = 32'h0; imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        m_pc = 32'h0; m_ret = '0; sb.delete();
        @(negedge clk);
    endtask

    // One full instruction: ack after ack_wait cycles, ready after ready_wait
    // extra cycles, then commit next_pc. Entered and left on a falling edge.
    task automatic run_instr(input logic [31:0] rdata, input int ack_wait,
                             input int ready_wait, input logic [31:0] next_pc);
        exp_t e;
        logic aligned;
        e.pc = m_pc; e.word = rdata;
        for (int i = 0; i < ack_wait; i++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
                n_fail++;
                $display("FAIL fetch_hold: req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, m_pc);
            end
            @(negedge clk);
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_req: req=%b addr=%h valid=%b want 1 %h 0", imem_req, imem_addr, instr_valid, m_pc);
        end
        imem_ack = 1'b1; imem_rdata = rdata; sb.push_back(e);
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;

        n_checks++;
        if (instr_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("FAIL issue_valid: valid=%b queued=%0d want valid=1", instr_valid, sb.size());
        end else begin
            e = sb.pop_front();
            if (instr !== e.word || instr_PC !== e.pc || imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL issue_data: instr=%h pc=%h req=%b want %h %h 0", instr, instr_PC, imem_req, e.word, e.pc);
            end
        end
        for (int j = 0; j < ready_wait; j++) begin
            @(negedge clk);
            n_checks++;
            if (instr_valid !== 1'b1 || instr !== e.word || instr_PC !== e.pc ||
                imem_req !== 1'b0 || PC !== m_pc) begin
                n_fail++;
                $display("FAIL issue_stall: valid=%b instr=%h req=%b pc=%h want 1 %h 0 %h", instr_valid, instr, imem_req, PC, e.word, m_pc);
            end
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;

        n_checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_exec: valid=%b req=%b want 0 0", instr_valid, imem_req);
        end
        pc_update = 1'b1; PC_next = next_pc;
        @(negedge clk);
        pc_update = 1'b0;
        aligned = (next_pc[1:0] == 2'b00);
        if (aligned) begin
            m_pc  = next_pc;
            m_ret = m_ret + 1'b1;
        end
        n_checks++;
        if (PC !== m_pc || instret !== m_ret || imem_req !== aligned ||
            misalign_fault !== !aligned || imem_addr !== m_pc) begin
            n_fail++;
            $display("FAIL commit: pc=%h ret=%0d req=%b fault=%b want %h %0d %b %b", PC, instret, imem_req, misalign_fault, m_pc, m_ret, aligned, !aligned);
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0; pc_update = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        PC_next = 32'h0; imem_rdata = 32'h0;
        @(negedge clk);
        n_checks++;
        if (PC !== 32'h0 || instret !== '0 || instr !== 32'h0 || instr_PC !== 32'h0 ||
            misalign_fault !== 1'b0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h ret=%0d instr=%h ipc=%h flt=%b req=%b vld=%b want all 0", PC, instret, instr, instr_PC, misalign_fault, imem_req, instr_valid);
        end
        apply_reset();
    endtask

    task automatic test_straight_line();
        run_instr(32'h0000_0013, 2, 0, 32'h4);
        n_checks++;
        if (PC !== 32'h4 || instret !== 4'd1 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL straight_line: pc=%h ret=%0d req=%b addr=%h want 4 1 1 4", PC, instret, imem_req, imem_addr);
        end
    endtask

    task automatic test_branch();
        run_instr(32'h0FC0_006F, 0, 0, 32'h0000_0100);
        n_checks++;
        if (imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL branch_addr: addr=%h want 00000100", imem_addr);
        end
        run_instr(32'h0010_0093, 1, 0, 32'h0000_0104);
    endtask

    task automatic test_backpressure();
        run_instr(32'h0020_8113, 0, 5, 32'h0000_0108);
    endtask

    task automatic test_spurious();
        exp_t e;
        // pc_update during FETCH
        pc_update = 1'b1; PC_next = 32'h800;
        @(negedge clk);
        pc_update = 1'b0;
        n_checks++;
        if (PC !== m_pc || instret !== m_ret || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL spur_fetch_upd: pc=%h ret=%0d req=%b want %h %0d 1", PC, instret, imem_req, m_pc, m_ret);
        end
        // ack and update together in FETCH: only the ack acts
        e.pc = m_pc; e.word = 32'h00A0_0513;
        imem_ack = 1'b1; imem_rdata = e.word; pc_update = 1'b1; PC_next = 32'h900;
        sb.push_back(e);
        @(negedge clk);
        imem_ack = 1'b0; pc_update = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("FAIL spur_simul_valid: valid=%b want 1", instr_valid);
        end else begin
            e = sb.pop_front();
            if (instr !== e.word || instr_PC !== e.pc || PC !== m_pc || instret !== m_ret) begin
                n_fail++;
                $display("FAIL spur_simul: instr=%h ipc=%h pc=%h ret=%0d want %h %h %h %0d", instr, instr_PC, PC, instret, e.word, e.pc, m_pc, m_ret);
            end
        end
        // pc_update during ISSUE
        pc_update = 1'b1; PC_next = 32'hA00;
        @(negedge clk);
        pc_update = 1'b0;
        n_checks++;
        if (PC !== m_pc || instret !== m_ret || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL spur_issue_upd: pc=%h ret=%0d valid=%b want %h %0d 1", PC, instret, instr_valid, m_pc, m_ret);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        // ack during WAIT_EXEC
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_ack = 1'b0;
        n_checks++;
        if (instr !== e.word || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_wait_ack: instr=%h valid=%b req=%b want %h 0 0", instr, instr_valid, imem_req, e.word);
        end
        pc_update = 1'b1; PC_next = m_pc + 32'h4;
        @(negedge clk);
        pc_update = 1'b0;
        m_pc = m_pc + 32'h4; m_ret = m_ret + 1'b1;
        n_checks++;
        if (PC !== m_pc || instret !== m_ret || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL spur_commit: pc=%h ret=%0d req=%b want %h %0d 1", PC, instret, imem_req, m_pc, m_ret);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] pc_before;
        pc_before = m_pc;
        run_instr(32'h0000_0067, 0, 0, 32'h0000_0102);
        for (int i = 0; i < 12; i++) begin
            imem_ack = i[0]; instr_ready = ~i[0]; pc_update = 1'b1; PC_next = 32'h200;
            @(negedge clk);
            n_checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_fault !== 1'b1 || PC !== pc_before) begin
                n_fail++;
                $display("FAIL fault_hold: req=%b valid=%b flt=%b pc=%h want 0 0 1 %h", imem_req, instr_valid, misalign_fault, PC, pc_before);
            end
        end
        imem_ack = 1'b0; instr_ready = 1'b0; pc_update = 1'b0;
        apply_reset();
        n_checks++;
        if (PC !== 32'h0 || misalign_fault !== 1'b0 || instret !== '0 || imem_req !== 1'b1 ||
            imem_addr !== 32'h0 || instr !== 32'h0) begin
            n_fail++;
            $display("FAIL fault_reset: pc=%h flt=%b ret=%0d req=%b instr=%h want 0 0 0 1 0", PC, misalign_fault, instret, imem_req, instr);
        end
    endtask

    task automatic test_async_reset_wrap();
        run_instr(32'h0000_0013, 0, 0, 32'h4);
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre: req=%b want 1", imem_req);
        end
        #2 n_reset = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || PC !== 32'h0 || instret !== '0 || instr !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: req=%b pc=%h ret=%0d instr=%h want 0 0 0 0", imem_req, PC, instret, instr);
        end
        @(negedge clk);
        n_reset = 1'b1;
        m_pc = 32'h0; m_ret = '0; sb.delete();
        @(negedge clk);
        for (int k = 0; k < 16; k++)
            run_instr(32'h0000_0013 + k, k % 2, 0, m_pc + 32'h4);
        n_checks++;
        if (instret !== 4'd0 || PC !== 32'h40) begin
            n_fail++;
            $display("FAIL count_wrap: ret=%0d pc=%h want 0 00000040", instret, PC);
        end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_branch();
        test_backpressure();
        test_spurious();
        test_misalign();
        test_async_reset_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
